// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock with a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res, res_next;
  logic [CW-1:0]    count;
  logic             br, br_next, d, a_msb, b_msb;
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {busy, done, bout, ovf, zero, br, a_msb, b_msb} <= '0;
      {diff, sa, sb, res} <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sa    <= a;
          sb    <= b;
          br    <= bin;
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
          count <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        br    <= br_next;
        res   <= res_next;
        count <= count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          diff  <= res_next;
          bout  <= br_next;
          ovf   <= (a_msb ^ b_msb) & (d ^ a_msb);
          zero  <= res_next == '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor that computes a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, using a single registered borrow bit. It is the subtract-direction counterpart to the team's combinational adder cell. It is intended for area-constrained datapaths where a full-width ripple subtractor is too large. Operands are captured on a start handshake; results are held until the next operation completes.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only while idle
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bin  input  1  borrow-in, captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result registers update
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow out (1 = unsigned underflow)
ovf  output  1  signed overflow of a - b - bin
zero  output  1  diff == 0

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset (async assert, any state): state=IDLE; busy, done, diff, bout, ovf, zero all 0; internal shift registers, borrow and bit counter cleared. Reset mid-operation discards the operation and produces no done pulse.
- States: IDLE, RUN. There is no separate done state.
- IDLE: at an edge with start=1, capture a, b and bin into shift registers and the borrow register. Save a[WIDTH-1] and b[WIDTH-1]. Set count=0 and go to RUN. busy=1 from this edge.
- RUN: each edge processes bit i = current LSB of the shift registers:
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the result register from the MSB end; the operand registers shift right.
  - count increments.
- Completion: the edge processing bit WIDTH-1 (the WIDTH-th RUN edge) does all of the following:
  - load diff with the full result; bout = br'
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb)
  - zero = (result == 0)
  - done=1, busy=0, state=IDLE
- Latency: start accepted at edge k; done high for exactly the cycle following edge k+WIDTH.
- done deasserts at the next edge unconditionally.
- diff/bout/ovf/zero change only at completion or reset and hold between operations.
- start while busy=1 is ignored. There is no queueing and captured operands are unaffected.
- start high during the done cycle is accepted, because the state is IDLE. This gives back-to-back operations at a throughput of one per WIDTH+1 cycles.
- Holding start high continuously restarts immediately after each done.
- Changes on a, b, bin outside the accept edge have no effect.
- WIDTH=1: a single RUN cycle; ovf uses bit 0 as the sign bit.
- Counter width is clog2(WIDTH+1); no wrap occurs within legal WIDTH.

Test Plan:
- WIDTH=8, a=0x5A, b=0x1F, bin=0, start one cycle -> busy for 8 cycles, then done pulse; diff=0x3B, bout=0, ovf=0, zero=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0; then a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1, zero=1.
- Start 0x5A-0x1F, then pulse start with a=0xFF, b=0x00 at cycle 3 of RUN -> ignored; result is still 0x3B at the original done time.
- Assert rst asynchronously (mid-cycle) at RUN bit 4 -> all outputs 0 immediately, no done pulse; a fresh start after release gives a correct result.
- start held high for three operations with operands changed on each done cycle -> done pulses every 9 cycles with matching results; a random self-check against the a-b-bin reference model (1000 vectors, WIDTH=1, 8, 32) all pass.
